// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared widths, defaults and types for the ADC sample capture block
package adc_capture_pkg;
  localparam int ADC_DATA_W = 9;
  localparam int DEF_CONV_CYCLES = 16;
  localparam int DEF_LOG2_AVG = 2;
  typedef logic [ADC_DATA_W-1:0] adc_sample_t;
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous FIFO with a registered head word (no fall-through)
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ADC_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [level_w(DEPTH)-1:0] o_level,
  output logic [WIDTH-1:0]          o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_head;
  logic             w_pop, w_push;
  logic [AW-1:0]    w_rd_next;
  assign o_full    = r_level == LW'(DEPTH);
  assign o_empty   = r_level == '0;
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign w_rd_next = r_rd + 1'b1;
  assign o_level   = r_level;
  assign o_head    = r_head;
  // storage array, written at the tail on every accepted push
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  // pointers, level and head register; head always mirrors r_mem[r_rd]
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= w_rd_next;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_push && (o_empty || (w_pop && r_level == LW'(1)))) r_head <= i_data;
      else if (w_pop && r_level > LW'(1)) r_head <= r_mem[w_rd_next];
    end
  end
endmodule

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: ADC sample tick, box-car averager and result FIFO (option: ADC_SAMPLE_CAPTURE_SIGNED_EN)
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int LOG2_AVG    = DEF_LOG2_AVG,
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_W      = ADC_DATA_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [DATA_W-1:0]              adc_data,
  input  logic                           clear_ovf,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                           overflow,
  output logic                           sample_tick
);
  localparam int CW = $clog2(CONV_CYCLES);
  localparam int AW = DATA_W + LOG2_AVG;
  localparam int NW = LOG2_AVG > 0 ? LOG2_AVG : 1;
  logic [CW-1:0]     r_tick_cnt;
  logic [AW-1:0]     r_acc;
  logic [NW-1:0]     r_cnt;
  logic              r_ovf;
  logic              w_tick, w_last, w_push, w_full, w_empty, w_drop;
  logic [AW-1:0]     w_sum;
  logic [DATA_W-1:0] w_avg, w_result;
  assign w_tick = enable && r_tick_cnt == CW'(CONV_CYCLES - 1);
  assign w_last = r_cnt == NW'((1 << LOG2_AVG) - 1);
  assign w_sum  = r_acc + AW'(adc_data);
  assign w_avg  = DATA_W'(w_sum >> LOG2_AVG);
`ifdef ADC_SAMPLE_CAPTURE_SIGNED_EN
  assign w_result = {~w_avg[DATA_W-1], w_avg[DATA_W-2:0]};
`else
  assign w_result = w_avg;
`endif
  assign w_push      = w_tick && w_last;
  assign w_drop      = w_push && w_full && !(out_valid && out_ready);
  assign out_valid   = !w_empty;
  assign overflow    = r_ovf;
  assign sample_tick = w_tick;
  // conversion-rate counter, parked at zero while capture is disabled
  always_ff @(posedge clock) begin
    if (reset || !enable) r_tick_cnt <= '0;
    else r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end
  // window accumulator; a disable discards any partial window
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_tick) begin
      r_acc <= w_last ? '0 : w_sum;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
  // sticky drop flag; a drop in the same cycle as clear_ovf keeps it set
  always_ff @(posedge clock) begin
    r_ovf <= !reset && (w_drop || (r_ovf && !clear_ovf));
  end
  adc_sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_push),
    .i_data (w_result),
    .i_pop  (out_ready),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(fifo_level),
    .o_head (out_data)
  );
endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: directed checks of averaging, FIFO, overflow, enable and reset behaviour
module tb_adc_sample_capture;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en_a = 1'b0, rdy_a = 1'b0, clr_a = 1'b0;
  logic [8:0] data_a = '0;
  logic       val_a, ovf_a, tick_a;
  logic [8:0] out_a;
  logic [3:0] lvl_a;
  logic       en_r = 1'b0, rdy_r = 1'b0, clr_r = 1'b0;
  logic [8:0] data_r = '0;
  logic       val_r, ovf_r, tick_r;
  logic [8:0] out_r;
  logic [3:0] lvl_r;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  adc_sample_capture #(.CONV_CYCLES(16), .LOG2_AVG(2), .FIFO_DEPTH(8), .DATA_W(9)) u_avg (
    .clock(clock), .reset(reset), .enable(en_a), .adc_data(data_a), .clear_ovf(clr_a),
    .out_valid(val_a), .out_ready(rdy_a), .out_data(out_a), .fifo_level(lvl_a),
    .overflow(ovf_a), .sample_tick(tick_a)
  );

  adc_sample_capture #(.CONV_CYCLES(4), .LOG2_AVG(0), .FIFO_DEPTH(8), .DATA_W(9)) u_raw (
    .clock(clock), .reset(reset), .enable(en_r), .adc_data(data_r), .clear_ovf(clr_r),
    .out_valid(val_r), .out_ready(rdy_r), .out_data(out_r), .fifo_level(lvl_r),
    .overflow(ovf_r), .sample_tick(tick_r)
  );

  function automatic logic [8:0] conv(input logic [8:0] x);
`ifdef ADC_SAMPLE_CAPTURE_SIGNED_EN
    return x ^ 9'h100;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic tick_wait_a(input int n);
    repeat (n - 1) step();
    chk("tick_a_pre", tick_a, 0);
    step();
    chk("tick_a", tick_a, 1);
  endtask

  task automatic tick_wait_r(input int n);
    repeat (n - 1) step();
    chk("tick_r_pre", tick_r, 0);
    step();
    chk("tick_r", tick_r, 1);
  endtask

  initial begin
    step();
    step();
    chk("rst_valid", {val_a, val_r}, 0);
    chk("rst_data", {out_a, out_r}, 0);
    chk("rst_level", {lvl_a, lvl_r}, 0);
    chk("rst_ovf", {ovf_a, ovf_r}, 0);
    chk("rst_tick", {tick_a, tick_r}, 0);
    reset = 1'b0;
    // 4-sample average of 100..103
    rdy_a = 1'b1;
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_wait_a(i == 0 ? 15 : 16);
      data_a = 9'(100 + i);
      chk("avg_no_early", val_a, 0);
    end
    step();
    chk("avg_valid", val_a, 1);
    chk("avg_data", out_a, conv(9'd101));
    chk("avg_level", lvl_a, 1);
    step();
    chk("avg_drained", val_a, 0);
    // partial window discarded on enable drop
    en_a = 1'b0;
    step();
    en_a = 1'b1;
    data_a = 9'd8;
    tick_wait_a(15);
    tick_wait_a(16);
    step();
    en_a = 1'b0;
    repeat (3) step();
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_wait_a(i == 0 ? 15 : 16);
      chk("part_no_out", val_a, 0);
    end
    step();
    chk("part_valid", val_a, 1);
    chk("part_data", out_a, conv(9'd8));
    step();
    // reset with level 5 and a half-filled window
    en_a = 1'b0;
    step();
    en_a = 1'b1;
    rdy_a = 1'b0;
    data_a = 9'd200;
    for (int i = 0; i < 22; i++) tick_wait_a(i == 0 ? 15 : 16);
    step();
    chk("pre_rst_level", lvl_a, 5);
    chk("pre_rst_data", out_a, conv(9'd200));
    reset = 1'b1;
    step();
    chk("mid_rst_valid", val_a, 0);
    chk("mid_rst_level", lvl_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_tick", tick_a, 0);
    reset = 1'b0;
    tick_wait_a(15);
    en_a = 1'b0;
    step();
    // overflow with pass-through, drop coincident with clear_ovf
    en_r = 1'b1;
    data_r = 9'h1FF;
    for (int i = 0; i < 9; i++) tick_wait_r(i == 0 ? 3 : 4);
    chk("full_level", lvl_r, 8);
    chk("full_no_ovf", ovf_r, 0);
    clr_r = 1'b1;
    step();
    clr_r = 1'b0;
    en_r = 1'b0;
    chk("ovf_set_wins", ovf_r, 1);
    chk("ovf_level", lvl_r, 8);
    chk("ovf_data", out_r, conv(9'h1FF));
    repeat (2) step();
    chk("ovf_sticky", ovf_r, 1);
    clr_r = 1'b1;
    step();
    clr_r = 1'b0;
    chk("ovf_cleared", ovf_r, 0);
    rdy_r = 1'b1;
    repeat (8) step();
    chk("drain_level", lvl_r, 0);
    chk("drain_valid", val_r, 0);
    rdy_r = 1'b0;
    // full FIFO with simultaneous push and pop keeps order
    en_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_wait_r(i == 0 ? 3 : 4);
      data_r = 9'(10 * (i + 1));
    end
    tick_wait_r(4);
    data_r = 9'd90;
    rdy_r = 1'b1;
    chk("pp_pre_level", lvl_r, 8);
    chk("pp_pre_head", out_r, conv(9'd10));
    step();
    en_r = 1'b0;
    chk("pp_level", lvl_r, 8);
    chk("pp_no_ovf", ovf_r, 0);
    chk("pp_head", out_r, conv(9'd20));
    for (int k = 1; k < 8; k++) begin
      step();
      chk("pp_order", out_r, conv(9'(20 + 10 * k)));
    end
    step();
    chk("pp_empty", val_r, 0);
    // output coding of 256, 0, 511
    rdy_r = 1'b0;
    en_r = 1'b1;
    tick_wait_r(3);
    data_r = 9'd256;
    tick_wait_r(4);
    data_r = 9'd0;
    tick_wait_r(4);
    data_r = 9'd511;
    step();
    en_r = 1'b0;
    chk("code_level", lvl_r, 3);
`ifdef ADC_SAMPLE_CAPTURE_SIGNED_EN
    chk("code_256", out_r, 9'h000);
    rdy_r = 1'b1;
    step();
    chk("code_0", out_r, 9'h100);
    step();
    chk("code_511", out_r, 9'h0FF);
`else
    chk("code_256", out_r, 9'h100);
    rdy_r = 1'b1;
    step();
    chk("code_0", out_r, 9'h000);
    step();
    chk("code_511", out_r, 9'h1FF);
`endif
    step();
    chk("code_empty", val_r, 0);
    // push and pop together at level 1 replaces the head
    rdy_r = 1'b0;
    en_r = 1'b1;
    tick_wait_r(3);
    data_r = 9'd5;
    step();
    chk("l1_level", lvl_r, 1);
    chk("l1_head", out_r, conv(9'd5));
    tick_wait_r(3);
    data_r = 9'd6;
    rdy_r = 1'b1;
    step();
    en_r = 1'b0;
    chk("l1_valid", val_r, 1);
    chk("l1_level_kept", lvl_r, 1);
    chk("l1_replaced", out_r, conv(9'd6));
    step();
    chk("l1_empty", val_r, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
